// File: rtl/tau_alu_pkg.sv
// Shared types for the ALU issue unit: opcodes, FSM states, flag bit positions.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package tau_alu_pkg;

    typedef enum logic [3:0] {
        NOP         = 4'd0,
        MOV         = 4'd1,
        CMP         = 4'd2,
        TEST        = 4'd3,
        SHFT_L      = 4'd4,
        SHFT_R      = 4'd5,
        ADD         = 4'd6,
        ADC         = 4'd7,
        SUB         = 4'd8,
        SBB         = 4'd9,
        MUL         = 4'd10,
        AND         = 4'd11,
        OR          = 4'd12,
        XOR         = 4'd13,
        NOT         = 4'd14,
        CLEAR_FLAGS = 4'd15
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2
    } issue_state_t;

    localparam int FLAG_Z = 7;
    localparam int FLAG_S = 6;
    localparam int FLAG_C = 5;
    localparam int FLAG_O = 4;

    // Compare/test/flag-only ops update flags but leave the register file alone.
    function automatic logic op_writes_rd(alu_op_t op);
        case (op)
            NOP, CMP, TEST, CLEAR_FLAGS: op_writes_rd = 1'b0;
            default:                     op_writes_rd = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// Register file for the ALU issue unit: two async operand reads, one async debug read, one sync write.
// Latency: reads are combinational; a write is visible after the writing clock edge.
// Backpressure: none; a write is accepted on every cycle we is high.
// Ports: clk/reset, ra_addr->ra_data, rb_addr->rb_data, dbg_addr->dbg_data, we/waddr/wdata.
// Macro ALU_ISSUE_ZERO_REG_EN: when defined R0 reads as 0 and writes to it are dropped.
module alu_issue_regfile
    import tau_alu_pkg::*;
#(
    parameter  int WORD_SIZE = 8,
    parameter  int NUM_REGS  = 8,
    localparam int REG_AW    = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_AW-1:0]    ra_addr,
    output logic [WORD_SIZE-1:0] ra_data,
    input  logic [REG_AW-1:0]    rb_addr,
    output logic [WORD_SIZE-1:0] rb_data,
    input  logic [REG_AW-1:0]    dbg_addr,
    output logic [WORD_SIZE-1:0] dbg_data,
    input  logic                 we,
    input  logic [REG_AW-1:0]    waddr,
    input  logic [WORD_SIZE-1:0] wdata
);

    logic [WORD_SIZE-1:0] regs [NUM_REGS];
    logic                 wr_ok;

`ifdef ALU_ISSUE_ZERO_REG_EN
    assign wr_ok    = (waddr != '0);
    assign ra_data  = (ra_addr  == '0) ? '0 : regs[ra_addr];
    assign rb_data  = (rb_addr  == '0) ? '0 : regs[rb_addr];
    assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];
`else
    assign wr_ok    = 1'b1;
    assign ra_data  = regs[ra_addr];
    assign rb_data  = regs[rb_addr];
    assign dbg_data = regs[dbg_addr];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && wr_ok) begin
            regs[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/alu_issue_unit.sv
// Execute stage feeding a combinational ALU: read operands, drive ALU, write result back.
// Latency: accept at edge N, register write and wb_valid at edge N+2, ready again after N+2.
// Backpressure: instr_ready is high only in IDLE; one instruction per 3 cycles.
// Ports: clk/reset; instr_valid/instr_ready/instr_op/rd/rs/imm_en/imm from the decoder;
//        alu_a/alu_b/alu_mode to the ALU, alu_c/alu_flags back; flags_q; wb_valid/addr/data;
//        dbg_addr/dbg_data debug read. Macro ALU_ISSUE_ZERO_REG_EN hardwires R0 to zero.
module alu_issue_unit
    import tau_alu_pkg::*;
#(
    parameter  int WORD_SIZE = 8,
    parameter  int NUM_REGS  = 8,
    localparam int REG_AW    = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [3:0]           instr_op,
    input  logic [REG_AW-1:0]    instr_rd,
    input  logic [REG_AW-1:0]    instr_rs,
    input  logic                 instr_imm_en,
    input  logic [WORD_SIZE-1:0] instr_imm,
    output logic [WORD_SIZE-1:0] alu_a,
    output logic [WORD_SIZE-1:0] alu_b,
    output logic [3:0]           alu_mode,
    input  logic [WORD_SIZE-1:0] alu_c,
    input  logic [7:0]           alu_flags,
    output logic [7:0]           flags_q,
    output logic                 wb_valid,
    output logic [REG_AW-1:0]    wb_addr,
    output logic [WORD_SIZE-1:0] wb_data,
    input  logic [REG_AW-1:0]    dbg_addr,
    output logic [WORD_SIZE-1:0] dbg_data
);

    issue_state_t         state, state_nx;
    alu_op_t              op_q;
    logic [REG_AW-1:0]    rd_q;
    logic [WORD_SIZE-1:0] a_q, b_q;
    logic [WORD_SIZE-1:0] ra_data, rb_data;
    logic                 accept, capture, do_write;

    // Operand A always comes from the destination register (two-address form).
    alu_issue_regfile #(
        .WORD_SIZE (WORD_SIZE),
        .NUM_REGS  (NUM_REGS)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .ra_addr  (instr_rd),
        .ra_data  (ra_data),
        .rb_addr  (instr_rs),
        .rb_data  (rb_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .we       (do_write),
        .waddr    (rd_q),
        .wdata    (alu_c)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (instr_valid) state_nx = ST_ISSUE;
            ST_ISSUE:   state_nx = ST_CAPTURE;
            ST_CAPTURE: state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        instr_ready = (state == ST_IDLE);
        capture     = (state == ST_CAPTURE);
        alu_mode    = (state == ST_IDLE) ? NOP : op_q;
        alu_a       = a_q;
        alu_b       = b_q;
    end

    assign accept   = instr_valid && instr_ready;
    assign do_write = capture && op_writes_rd(op_q);

    // Issue register and capture/writeback registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q     <= NOP;
            rd_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            flags_q  <= '0;
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
        end else begin
            wb_valid <= do_write;
            if (accept) begin
                op_q <= alu_op_t'(instr_op);
                rd_q <= instr_rd;
                a_q  <= ra_data;
                b_q  <= instr_imm_en ? instr_imm : rb_data;
            end
            if (capture) begin
                flags_q <= alu_flags;
            end
            if (do_write) begin
                wb_addr <= rd_q;
                wb_data <= alu_c;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_unit.sv
module tb_alu_issue_unit;
    import tau_alu_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] instr_op;
    logic [2:0] instr_rd, instr_rs;
    logic       instr_imm_en;
    logic [7:0] instr_imm;
    logic [7:0] alu_a, alu_b, alu_c;
    logic [3:0] alu_mode;
    logic [7:0] alu_flags, flags_q;
    logic       wb_valid;
    logic [2:0] wb_addr;
    logic [7:0] wb_data;
    logic [2:0] dbg_addr;
    logic [7:0] dbg_data;

    int checks   = 0;
    int failures = 0;

    logic       wbv_s;
    logic [2:0] wba_s;
    logic [7:0] wbd_s;
    logic [7:0] r0_exp;

    logic [3:0] v_op  [3] = '{MOV, ADD, MOV};
    int         v_rd  [3] = '{5, 5, 6};
    int         v_rs  [3] = '{0, 0, 5};
    logic       v_ie  [3] = '{1'b1, 1'b1, 1'b0};
    logic [7:0] v_imm [3] = '{8'd7, 8'd3, 8'd0};

    always #5 clk = ~clk;

    alu_issue_unit #(.WORD_SIZE(8), .NUM_REGS(8)) dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
        .instr_rd(instr_rd), .instr_rs(instr_rs), .instr_imm_en(instr_imm_en),
        .instr_imm(instr_imm), .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode),
        .alu_c(alu_c), .alu_flags(alu_flags), .flags_q(flags_q),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Reference ALU: carry-in for ADC/SBB comes from the flag register the unit keeps.
    function automatic logic [15:0] alu_model(logic [3:0] m, logic [7:0] a, logic [7:0] b, logic cin);
        logic [8:0] r;
        logic [7:0] c;
        logic       cf, of;
        r  = '0;
        c  = '0;
        cf = 1'b0;
        of = 1'b0;
        case (m)
            MOV:    c = b;
            CMP, SUB: begin
                r = {1'b0, a} - {1'b0, b}; c = r[7:0]; cf = r[8];
                of = (a[7] != b[7]) && (c[7] != a[7]);
            end
            SBB: begin
                r = {1'b0, a} - {1'b0, b} - {8'd0, cin}; c = r[7:0]; cf = r[8];
                of = (a[7] != b[7]) && (c[7] != a[7]);
            end
            TEST, AND: c = a & b;
            SHFT_L: begin c = {a[6:0], 1'b0}; cf = a[7]; end
            SHFT_R: begin c = {1'b0, a[7:1]}; cf = a[0]; end
            ADD: begin
                r = {1'b0, a} + {1'b0, b}; c = r[7:0]; cf = r[8];
                of = (a[7] == b[7]) && (c[7] != a[7]);
            end
            ADC: begin
                r = {1'b0, a} + {1'b0, b} + {8'd0, cin}; c = r[7:0]; cf = r[8];
                of = (a[7] == b[7]) && (c[7] != a[7]);
            end
            MUL: c = 8'(a * b);
            OR:  c = a | b;
            XOR: c = a ^ b;
            NOT: c = ~a;
            default: return 16'h0000;
        endcase
        return {(c == 8'd0), c[7], cf, of, 4'b0000, c};
    endfunction

    always_comb begin
        {alu_flags, alu_c} = alu_model(alu_mode, alu_a, alu_b, flags_q[FLAG_C]);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input int addr, input logic [7:0] exp);
        @(negedge clk);
        dbg_addr = 3'(addr);
        #1;
        chk(tag, 32'(dbg_data), 32'(exp));
    endtask

    task automatic drive(input logic [3:0] op, input int rd, input int rs, input logic ie, input logic [7:0] imm);
        instr_op     = op;
        instr_rd     = 3'(rd);
        instr_rs     = 3'(rs);
        instr_imm_en = ie;
        instr_imm    = imm;
    endtask

    // One instruction through the full handshake; samples writeback just after edge N+2.
    task automatic run(input logic [3:0] op, input int rd, input int rs, input logic ie, input logic [7:0] imm);
        bit acc = 1'b0;
        @(negedge clk);
        drive(op, rd, rs, ie, imm);
        instr_valid = 1'b1;
        for (int i = 0; i < 10 && !acc; i++) begin
            if (instr_ready) acc = 1'b1;
            else @(negedge clk);
        end
        chk("accept_timeout", 32'(acc), 32'd1);
        if (!acc) begin
            instr_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        instr_valid = 1'b0;
        instr_imm   = ~imm;
        @(posedge clk);
        @(posedge clk); #1;
        wbv_s = wb_valid;
        wba_s = wb_addr;
        wbd_s = wb_data;
    endtask

    // Reset while an ADD r1 is in flight: hold=0 hits ISSUE, hold=1 hits CAPTURE.
    task automatic abort(input int hold, input string tag);
        bit seen = 1'b0;
        @(negedge clk);
        chk({tag, "_ready_before"}, 32'(instr_ready), 32'd1);
        drive(ADD, 1, 0, 1'b1, 8'd5);
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        repeat (hold) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (wb_valid) seen = 1'b1;
        end
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (wb_valid) seen = 1'b1;
        end
        chk({tag, "_no_wb"},  32'(seen),        32'd0);
        chk({tag, "_flags"},  32'(flags_q),     32'd0);
        chk({tag, "_ready"},  32'(instr_ready), 32'd1);
        chk_reg({tag, "_r1"}, 1, 8'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int  idx;
        bit  took;
        int  acc_cyc [3];

        reset       = 1'b1;
        instr_valid = 1'b0;
        dbg_addr    = '0;
        drive(NOP, 0, 0, 1'b0, 8'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;

        // Reset state
        chk("rst_ready",   32'(instr_ready), 32'd1);
        chk("rst_wbv",     32'(wb_valid),    32'd0);
        chk("rst_wba",     32'(wb_addr),     32'd0);
        chk("rst_wbd",     32'(wb_data),     32'd0);
        chk("rst_alu_a",   32'(alu_a),       32'd0);
        chk("rst_alu_b",   32'(alu_b),       32'd0);
        chk("rst_mode",    32'(alu_mode),    32'(NOP));
        chk("rst_flags",   32'(flags_q),     32'd0);
        chk_reg("rst_r3", 3, 8'd0);

        // 1: MOV r1, #10 with cycle-by-cycle timing
        @(negedge clk);
        drive(MOV, 1, 0, 1'b1, 8'd10);
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        instr_imm   = 8'd99;
        chk("t1_ready_issue", 32'(instr_ready), 32'd0);
        chk("t1_mode_issue",  32'(alu_mode),    32'(MOV));
        chk("t1_b_issue",     32'(alu_b),       32'd10);
        @(posedge clk); #1;
        chk("t1_ready_cap",   32'(instr_ready), 32'd0);
        chk("t1_wbv_cap",     32'(wb_valid),    32'd0);
        @(posedge clk); #1;
        chk("t1_wbv",         32'(wb_valid),    32'd1);
        chk("t1_wba",         32'(wb_addr),     32'd1);
        chk("t1_wbd",         32'(wb_data),     32'd10);
        chk("t1_ready_back",  32'(instr_ready), 32'd1);
        @(posedge clk); #1;
        chk("t1_wbv_pulse",   32'(wb_valid),    32'd0);
        chk_reg("t1_r1", 1, 8'd10);

        // 2: arithmetic and flags
        run(ADD, 1, 0, 1'b1, 8'd30);
        chk("t2_add_wbd", 32'(wbd_s), 32'd40);
        chk_reg("t2_r1", 1, 8'd40);
        chk("t2_add_flags", 32'(flags_q[7:4]), 32'd0);
        run(MOV, 3, 0, 1'b1, 8'd1);
        run(MOV, 2, 0, 1'b1, 8'd255);
        run(ADD, 2, 0, 1'b1, 8'd1);
        chk_reg("t2_r2", 2, 8'd0);
        chk("t2_wrap_flags", 32'(flags_q), 32'h000000A0);
        run(ADC, 3, 0, 1'b1, 8'd0);
        chk("t2_adc_wbd", 32'(wbd_s), 32'd2);
        chk_reg("t2_r3", 3, 8'd2);

        // 3: compare does not write; rd == rs hazard
        run(MOV, 4, 0, 1'b1, 8'd40);
        run(CMP, 4, 0, 1'b1, 8'd50);
        chk("t3_cmp_wbv", 32'(wbv_s), 32'd0);
        chk_reg("t3_r4", 4, 8'd40);
        chk("t3_cmp_flags", 32'(flags_q), 32'h00000060);
        run(ADD, 4, 4, 1'b0, 8'd0);
        chk("t3_hazard_wbd", 32'(wbd_s), 32'd80);
        chk_reg("t3_r4_sum", 4, 8'd80);

        // 4: instr_valid held high across three instructions
        @(negedge clk);
        drive(v_op[0], v_rd[0], v_rs[0], v_ie[0], v_imm[0]);
        instr_valid = 1'b1;
        idx = 0;
        for (int cyc = 0; cyc < 30 && idx < 3; cyc++) begin
            took = 1'b0;
            if (instr_ready) begin
                acc_cyc[idx] = cyc;
                idx++;
                took = 1'b1;
            end
            @(posedge clk); #1;
            if (took) begin
                if (idx < 3) drive(v_op[idx], v_rd[idx], v_rs[idx], v_ie[idx], v_imm[idx]);
                else instr_valid = 1'b0;
            end
            @(negedge clk);
        end
        instr_valid = 1'b0;
        chk("t4_accepts", 32'(idx), 32'd3);
        if (idx == 3) begin
            chk("t4_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
            chk("t4_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
        end
        repeat (3) @(posedge clk);
        chk_reg("t4_r5", 5, 8'd10);
        chk_reg("t4_r6", 6, 8'd10);

        // 5: reset aborts in-flight instruction
        abort(0, "t5_issue");
        abort(1, "t5_capture");

        // 6: R0 behaviour, boundary registers 7 and 0
`ifdef ALU_ISSUE_ZERO_REG_EN
        r0_exp = 8'd0;
`else
        r0_exp = 8'd5;
`endif
        run(MOV, 0, 0, 1'b1, 8'd5);
        chk("t6_wbv", 32'(wbv_s), 32'd1);
        chk("t6_wba", 32'(wba_s), 32'd0);
        chk_reg("t6_r0", 0, r0_exp);
        run(MOV, 7, 0, 1'b0, 8'd0);
        chk("t6_r7_wbd", 32'(wbd_s), 32'(r0_exp));
        chk_reg("t6_r7", 7, r0_exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
